// File: rtl/yurutucu.sv
// yurutucu: Tomasulo-style out-of-order core, 4x32-bit registers, ADD/MUL units sharing one CDB.
// Optional macro YURUTUCU_STATS_EN adds the komut_sayisi issued-instruction counter.
module yurutucu #(
  parameter int ADD_RS_N = 2,
  parameter int MUL_RS_N = 2,
  parameter int MUL_LAT  = 2
) (
  input  logic         saat,
  input  logic         sifirla,
  input  logic [1:0]   ky1,
  input  logic [1:0]   ky2,
  input  logic [1:0]   hy,
  input  logic         islem,
  input  logic         bitir,
  output logic         hazir,
  output logic         bitti,
`ifdef YURUTUCU_STATS_EN
  output logic [31:0]  komut_sayisi,
`endif
  output logic [127:0] yazmac_degerleri
);
  localparam int N  = ADD_RS_N + MUL_RS_N;
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  typedef logic [TW-1:0] tag_t;

  // Registers are held XOR 1, so an all-zero power-up state reads back as R0..R3 = 1.
  logic [3:0][31:0] regs_x_q;
  logic [3:0]       stat_v_q;
  tag_t             stat_q [4];
  logic [31:0]      rf [4];

  logic [N-1:0] busy_q, exec_q, vj_ok_q, vk_ok_q;
  logic [31:0]  vj_q [N];
  logic [31:0]  vk_q [N];
  tag_t         qj_q [N];
  tag_t         qk_q [N];
  logic [3:0]   age_q [N];

  logic         mul_busy_q;
  logic [7:0]   mul_cnt_q;
  tag_t         mul_tag_q;
  logic [31:0]  mul_res_q;
  logic         add_hold_q;
  tag_t         add_hold_tag_q;
  logic [31:0]  add_hold_val_q;

  logic [N-1:0] rdy;
  logic         add_sel_v, mul_sel_v, add_free_v, mul_free_v;
  tag_t         add_sel, mul_sel, add_free, mul_free, iss_tag;
  logic [3:0]   add_best, mul_best;
  logic         mul_start, mul_bc, add_start, add_bc, add_to_hold;
  tag_t         mul_bc_tag;
  logic [31:0]  mul_bc_val, mul_prod, add_sum;
  logic         cdb_v;
  tag_t         cdb_tag;
  logic [31:0]  cdb_val;
  logic         j_ok, k_ok;
  logic [31:0]  j_val, k_val;
  tag_t         j_tag, k_tag;

  always_comb begin
    for (int r = 0; r < 4; r++) rf[r] = regs_x_q[r] ^ 32'd1;
  end
  assign yazmac_degerleri = {rf[0], rf[1], rf[2], rf[3]};

  assign rdy = busy_q & ~exec_q & vj_ok_q & vk_ok_q;

  // Oldest ready entry per unit type (largest age); lowest free slot per type for issue.
  always_comb begin
    add_sel_v = 1'b0; add_sel = '0; add_best = '0;
    mul_sel_v = 1'b0; mul_sel = '0; mul_best = '0;
    add_free_v = 1'b0; add_free = '0;
    mul_free_v = 1'b0; mul_free = '0;
    for (int i = 0; i < N; i++) begin
      if (i < ADD_RS_N) begin
        if (rdy[i] && (!add_sel_v || age_q[i] > add_best)) begin
          add_sel_v = 1'b1; add_sel = tag_t'(i); add_best = age_q[i];
        end
      end else if (rdy[i] && (!mul_sel_v || age_q[i] > mul_best)) begin
        mul_sel_v = 1'b1; mul_sel = tag_t'(i); mul_best = age_q[i];
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        if (i < ADD_RS_N) begin
          add_free_v = 1'b1; add_free = tag_t'(i);
        end else begin
          mul_free_v = 1'b1; mul_free = tag_t'(i);
        end
      end
    end
  end

  assign iss_tag = islem ? add_free : mul_free;
  assign hazir   = ~bitir & (islem ? add_free_v : mul_free_v);
  assign bitti   = bitir & ~(|busy_q) & ~mul_busy_q & ~add_hold_q;

  assign mul_start = mul_sel_v & ~mul_busy_q;
  assign mul_prod  = vj_q[mul_sel] * vk_q[mul_sel];
  always_comb begin
    if (MUL_LAT == 1) begin
      mul_bc = mul_start; mul_bc_tag = mul_sel; mul_bc_val = mul_prod;
    end else begin
      mul_bc = mul_busy_q && (mul_cnt_q == 8'd1); mul_bc_tag = mul_tag_q; mul_bc_val = mul_res_q;
    end
  end

  // A finished ADD that loses the CDB to MUL parks in the hold register and stalls new ADDs.
  assign add_start   = add_sel_v & ~add_hold_q;
  assign add_sum     = vj_q[add_sel] + vk_q[add_sel];
  assign add_bc      = ~mul_bc & (add_hold_q | add_start);
  assign add_to_hold = add_start & mul_bc;

  assign cdb_v   = mul_bc | add_bc;
  assign cdb_tag = mul_bc ? mul_bc_tag : (add_hold_q ? add_hold_tag_q : add_sel);
  assign cdb_val = mul_bc ? mul_bc_val : (add_hold_q ? add_hold_val_q : add_sum);

  always_comb begin
    j_ok = 1'b1; j_val = rf[ky1]; j_tag = stat_q[ky1];
    if (stat_v_q[ky1]) begin
      if (cdb_v && stat_q[ky1] == cdb_tag) j_val = cdb_val;
      else j_ok = 1'b0;
    end
    k_ok = 1'b1; k_val = rf[ky2]; k_tag = stat_q[ky2];
    if (stat_v_q[ky2]) begin
      if (cdb_v && stat_q[ky2] == cdb_tag) k_val = cdb_val;
      else k_ok = 1'b0;
    end
  end

  always_ff @(posedge saat) begin
    if (sifirla) begin
      regs_x_q   <= '0;
      stat_v_q   <= '0;
      busy_q     <= '0;
      exec_q     <= '0;
      mul_busy_q <= 1'b0;
      add_hold_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (busy_q[i] && age_q[i] != 4'hF) age_q[i] <= age_q[i] + 4'd1;
      end
      if (add_start) exec_q[add_sel] <= 1'b1;
      if (add_to_hold) begin
        add_hold_q <= 1'b1; add_hold_tag_q <= add_sel; add_hold_val_q <= add_sum;
      end else if (add_hold_q && add_bc) begin
        add_hold_q <= 1'b0;
      end
      if (mul_start) begin
        exec_q[mul_sel] <= 1'b1;
        if (MUL_LAT > 1) begin
          mul_busy_q <= 1'b1; mul_cnt_q <= 8'(MUL_LAT - 1);
          mul_tag_q  <= mul_sel; mul_res_q <= mul_prod;
        end
      end else if (mul_busy_q) begin
        if (mul_cnt_q == 8'd1) mul_busy_q <= 1'b0;
        else mul_cnt_q <= mul_cnt_q - 8'd1;
      end
      if (cdb_v) begin
        for (int i = 0; i < N; i++) begin
          if (busy_q[i] && !vj_ok_q[i] && qj_q[i] == cdb_tag) begin
            vj_q[i] <= cdb_val; vj_ok_q[i] <= 1'b1;
          end
          if (busy_q[i] && !vk_ok_q[i] && qk_q[i] == cdb_tag) begin
            vk_q[i] <= cdb_val; vk_ok_q[i] <= 1'b1;
          end
        end
        busy_q[cdb_tag] <= 1'b0;
        exec_q[cdb_tag] <= 1'b0;
        for (int r = 0; r < 4; r++) begin
          if (stat_v_q[r] && stat_q[r] == cdb_tag) begin
            regs_x_q[r] <= cdb_val ^ 32'd1; stat_v_q[r] <= 1'b0;
          end
        end
      end
      // Issue goes last so the new destination tag wins over a same-edge CDB clear.
      if (hazir) begin
        busy_q[iss_tag]  <= 1'b1;
        exec_q[iss_tag]  <= 1'b0;
        age_q[iss_tag]   <= 4'd0;
        vj_ok_q[iss_tag] <= j_ok; vj_q[iss_tag] <= j_val; qj_q[iss_tag] <= j_tag;
        vk_ok_q[iss_tag] <= k_ok; vk_q[iss_tag] <= k_val; qk_q[iss_tag] <= k_tag;
        stat_v_q[hy]     <= 1'b1;
        stat_q[hy]       <= iss_tag;
      end
    end
  end

`ifdef YURUTUCU_STATS_EN
  logic [31:0] komut_q;
  always_ff @(posedge saat) begin
    if (sifirla) komut_q <= '0;
    else if (hazir) komut_q <= komut_q + 32'd1;
  end
  assign komut_sayisi = komut_q;
`endif

endmodule

// File: tb/tb_yurutucu.sv
// Self-checking bench for yurutucu: sequential register model feeds an expected-state queue.
module tb_yurutucu;
  logic         saat = 1'b0;
  logic         sifirla, islem, bitir;
  logic [1:0]   ky1, ky2, hy;
  logic         hazir, bitti;
  logic [127:0] yazmac_degerleri;
`ifdef YURUTUCU_STATS_EN
  logic [31:0]  komut_sayisi;
`endif

  always #5 saat = ~saat;

  yurutucu dut (
    .saat(saat), .sifirla(sifirla), .ky1(ky1), .ky2(ky2), .hy(hy),
    .islem(islem), .bitir(bitir), .hazir(hazir), .bitti(bitti),
`ifdef YURUTUCU_STATS_EN
    .komut_sayisi(komut_sayisi),
`endif
    .yazmac_degerleri(yazmac_degerleri)
  );

  localparam logic [127:0] ALL_ONES = {32'd1, 32'd1, 32'd1, 32'd1};

  logic [31:0]  mdl [4];
  logic [127:0] exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_issued = 0;
  logic         last_stall;

  function automatic logic [127:0] mdl_pack();
    return {mdl[0], mdl[1], mdl[2], mdl[3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge saat);
    sifirla = 1'b1; bitir = 1'b1;
    @(negedge saat);
    sifirla = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) mdl[r] = 32'd1;
    n_issued = 0;
  endtask

  // Drive one instruction and hold it until accepted; ends 1 time unit after the next negedge.
  task automatic issue(input logic op, input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2);
    int w;
    islem = op; hy = d; ky1 = s1; ky2 = s2; bitir = 1'b0;
    #1;
    last_stall = ~hazir;
    w = 0;
    while (!hazir && w < 20) begin
      @(negedge saat); #1; w++;
    end
    if (!hazir) check("issue_timeout", {127'd0, hazir}, 128'd1);
    else n_issued++;
    @(posedge saat);
    if (op) mdl[d] = mdl[s1] + mdl[s2];
    else    mdl[d] = mdl[s1] * mdl[s2];
    @(negedge saat);
    bitir = 1'b1;
    #1;
  endtask

  task automatic drain(input string tag);
    int w;
    logic [127:0] e;
    w = 0;
    while (!bitti && w < 100) begin
      @(negedge saat); #1; w++;
    end
    check({tag, "_bitti"}, {127'd0, bitti}, 128'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, yazmac_degerleri, e);
    end else begin
      check({tag, "_queue_empty"}, 128'd0, 128'd1);
    end
  endtask

  logic s1_stall, s2_stall;

  initial begin
    sifirla = 1'b1; bitir = 1'b1; islem = 1'b1; ky1 = 2'd0; ky2 = 2'd0; hy = 2'd0;
    do_reset();
    check("rst_regs", yazmac_degerleri, ALL_ONES);
    check("rst_bitti", {127'd0, bitti}, 128'd1);
    check("rst_hazir_bitir", {127'd0, hazir}, 128'd0);
    bitir = 1'b0; #1;
    check("idle_bitti", {127'd0, bitti}, 128'd0);
    check("idle_hazir", {127'd0, hazir}, 128'd1);
    check("idle_regs", yazmac_degerleri, ALL_ONES);
    bitir = 1'b1; #1;

    // Single ADD R2 <- R0 + R1
    issue(1'b1, 2'd2, 2'd0, 2'd1);
    exp_q.push_back(mdl_pack());
    check("add_pre_wb", yazmac_degerleri, ALL_ONES);
    check("add_pre_bitti", {127'd0, bitti}, 128'd0);
    @(negedge saat); #1;
    check("add_wb", yazmac_degerleri, {32'd1, 32'd1, 32'd2, 32'd1});
    check("add_wb_bitti", {127'd0, bitti}, 128'd1);
    drain("add_final");

    // ADD then dependent MUL R0 <- R2 * R3
    do_reset();
    issue(1'b1, 2'd2, 2'd0, 2'd1);
    check("dep_before_add", yazmac_degerleri, ALL_ONES);
    issue(1'b0, 2'd0, 2'd2, 2'd3);
    exp_q.push_back(mdl_pack());
    check("dep_after_add", yazmac_degerleri, {32'd1, 32'd1, 32'd2, 32'd1});
    @(negedge saat); #1;
    check("dep_mul_busy", yazmac_degerleri, {32'd1, 32'd1, 32'd2, 32'd1});
    check("dep_mul_busy_bitti", {127'd0, bitti}, 128'd0);
    @(negedge saat); #1;
    check("dep_mul_wb", yazmac_degerleri, {32'd2, 32'd1, 32'd2, 32'd1});
    check("dep_mul_bitti", {127'd0, bitti}, 128'd1);
    drain("dep_final");

    // WAW: MUL R1 then ADD R1; the ADD result must survive
    do_reset();
    issue(1'b0, 2'd1, 2'd0, 2'd0);
    issue(1'b1, 2'd1, 2'd0, 2'd0);
    exp_q.push_back(mdl_pack());
    @(negedge saat); #1;
    check("waw_mul_no_write", yazmac_degerleri, ALL_ONES);
    @(negedge saat); #1;
    check("waw_add_wb", yazmac_degerleri, {32'd1, 32'd2, 32'd1, 32'd1});
    repeat (3) @(negedge saat);
    #1;
    drain("waw_final");

    // Same ADD held for three edges: chained doubling of R0
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b1, 2'd0, 2'd0, 2'd0);
    exp_q.push_back(mdl_pack());
    drain("chain_final");
    check("chain_r0", {96'd0, yazmac_degerleri[127:96]}, 128'd8);

    // Build R0 = 0xFFFFFFFF, then three back-to-back MULs with only two MUL stations
    do_reset();
    issue(1'b1, 2'd2, 2'd1, 2'd1);
    for (int i = 0; i < 31; i++) begin
      issue(1'b1, 2'd0, 2'd0, 2'd0);
      issue(1'b1, 2'd0, 2'd0, 2'd1);
    end
    exp_q.push_back(mdl_pack());
    drain("build_final");
    check("build_r0", {96'd0, yazmac_degerleri[127:96]}, {96'd0, 32'hFFFFFFFF});
    issue(1'b0, 2'd3, 2'd0, 2'd2);
    s1_stall = last_stall;
    issue(1'b0, 2'd1, 2'd2, 2'd2);
    s2_stall = last_stall;
    issue(1'b0, 2'd2, 2'd0, 2'd0);
    check("stall_1st", {127'd0, s1_stall}, 128'd0);
    check("stall_2nd", {127'd0, s2_stall}, 128'd0);
    check("stall_3rd", {127'd0, last_stall}, 128'd1);
    exp_q.push_back(mdl_pack());
    drain("stall_final");
    check("wrap_r3", {96'd0, yazmac_degerleri[31:0]}, {96'd0, 32'hFFFFFFFE});
`ifdef YURUTUCU_STATS_EN
    check("stats_count", {96'd0, komut_sayisi}, {96'd0, 32'(n_issued)});
`endif

    // Reset while a MUL is in flight: no late write
    do_reset();
    issue(1'b1, 2'd1, 2'd0, 2'd0);
    exp_q.push_back(mdl_pack());
    drain("pre_mid_rst");
    issue(1'b0, 2'd0, 2'd1, 2'd1);
    sifirla = 1'b1;
    @(negedge saat);
    sifirla = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) mdl[r] = 32'd1;
    check("mid_rst_regs", yazmac_degerleri, ALL_ONES);
    check("mid_rst_bitti", {127'd0, bitti}, 128'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge saat); #1;
      check("mid_rst_no_late", yazmac_degerleri, ALL_ONES);
    end
`ifdef YURUTUCU_STATS_EN
    check("stats_reset", {96'd0, komut_sayisi}, 128'd0);
`endif
    exp_q.push_back(mdl_pack());
    drain("mid_rst_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end
endmodule
